ascii_num_parser: RTL

Upstream stage of the number storage RAM. Consumes an ASCII byte stream of signed decimal integers separated by delimiters and converts each integer to two's-complement DATA_WIDTH. Writes each result to consecutive RAM addresses from 0. Issues the RAM clear at session start and waits out the full clear sweep before the first write.

---
 rtl/ascii_num_parser.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ascii_num_parser.sv
// Parses an ASCII stream of signed decimal integers into two's-complement words for the number RAM.
// Define ASCII_NUM_HEX_EN to also accept 0x/0X-prefixed hexadecimal numbers.
module ascii_num_parser #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 2048,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic                  ram_clear,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic [ADDR_WIDTH:0]   num_count,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int CW = ADDR_WIDTH + 1;
   localparam int MW = DATA_WIDTH + 1;
   localparam int EW = DATA_WIDTH + 6;
   localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
   localparam logic [MW-1:0]         MAG_MIN = {2'b01, {(DATA_WIDTH - 1){1'b0}}};
   // Any magnitude above MAG_MIN overflows for both signs, so the accumulator pins one past it.
   localparam logic [MW-1:0]         MAG_CAP = MAG_MIN + MW'(1);
   localparam logic [DATA_WIDTH-1:0] POS_MAX = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] NEG_MIN = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

   typedef enum logic [2:0] {StIdle, StClearWait, StParse, StFlush, StDone} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         clr_cnt_q, clr_cnt_d;
   logic [MW-1:0]         acc_q, acc_d;
   logic                  neg_q, neg_d;
   logic                  in_num_q, in_num_d;
   logic [CW-1:0]         num_count_q, num_count_d;
   logic                  error_q, error_d;
   logic                  ram_clear_q, ram_clear_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
`ifdef ASCII_NUM_HEX_EN
   logic                  hex_q, hex_d;
   logic                  first_zero_q, first_zero_d;
   logic                  is_x;
`endif

   logic                  is_delim, is_minus, is_digit;
   logic [3:0]            dig_val;
   logic [EW-1:0]         prod;
   logic [MW-1:0]         acc_next;
   logic [DATA_WIDTH-1:0] emit_val;
   logic                  emit_ovf;
   logic                  emit, clear_num;

   always_comb begin
      is_delim = (in_data == 8'h20) || (in_data == 8'h2C) || (in_data == 8'h0A) ||
                 (in_data == 8'h0D) || (in_data == 8'h09);
      is_minus = (in_data == 8'h2D);
      is_digit = 1'b0;
      dig_val  = 4'd0;
      if (in_data >= 8'h30 && in_data <= 8'h39) begin
         is_digit = 1'b1;
         dig_val  = 4'(in_data - 8'h30);
      end
`ifdef ASCII_NUM_HEX_EN
      is_x = (in_data == 8'h78) || (in_data == 8'h58);
      if (hex_q && in_data >= 8'h61 && in_data <= 8'h66) begin
         is_digit = 1'b1;
         dig_val  = 4'(in_data - 8'h57);
      end else if (hex_q && in_data >= 8'h41 && in_data <= 8'h46) begin
         is_digit = 1'b1;
         dig_val  = 4'(in_data - 8'h37);
      end
`endif
   end

   always_comb begin
      prod = (EW'(acc_q) << 3) + (EW'(acc_q) << 1) + EW'(dig_val);
`ifdef ASCII_NUM_HEX_EN
      if (hex_q) prod = (EW'(acc_q) << 4) + EW'(dig_val);
`endif
      acc_next = (prod > EW'(MAG_CAP)) ? MAG_CAP : prod[MW-1:0];
   end

   always_comb begin
      emit_ovf = 1'b0;
      emit_val = acc_q[DATA_WIDTH-1:0];
      if (neg_q) begin
         if (acc_q > MAG_MIN) begin
            emit_val = NEG_MIN;
            emit_ovf = 1'b1;
         end else begin
            emit_val = -acc_q[DATA_WIDTH-1:0];
         end
      end else if (acc_q >= MAG_MIN) begin
         emit_val = POS_MAX;
         emit_ovf = 1'b1;
      end
   end

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      acc_d       = acc_q;
      neg_d       = neg_q;
      in_num_d    = in_num_q;
      num_count_d = num_count_q;
      error_d     = error_q;
      ram_clear_d = 1'b0;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      emit        = 1'b0;
      clear_num   = 1'b0;
`ifdef ASCII_NUM_HEX_EN
      hex_d        = hex_q;
      first_zero_d = first_zero_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d     = StClearWait;
               ram_clear_d = 1'b1;
               clr_cnt_d   = '0;
               num_count_d = '0;
               error_d     = 1'b0;
               clear_num   = 1'b1;
            end
         end
         StClearWait: begin
            // The RAM needs DEPTH cycles after the clear pulse before it accepts writes.
            if (clr_cnt_q == DEPTH_C) state_d = StParse;
            else clr_cnt_d = clr_cnt_q + CW'(1);
         end
         StParse: begin
            if (in_valid) begin
               if (is_delim) begin
                  emit      = in_num_q;
                  clear_num = 1'b1;
                  if (neg_q && !in_num_q) error_d = 1'b1;
               end else if (is_minus) begin
                  if (!in_num_q && !neg_q) neg_d = 1'b1;
                  else error_d = 1'b1;
               end else if (is_digit) begin
                  acc_d    = acc_next;
                  in_num_d = 1'b1;
`ifdef ASCII_NUM_HEX_EN
                  first_zero_d = !in_num_q && (in_data == 8'h30);
`endif
               end
`ifdef ASCII_NUM_HEX_EN
               else if (is_x && first_zero_q) begin
                  hex_d        = 1'b1;
                  first_zero_d = 1'b0;
               end
`endif
               else begin
                  error_d = 1'b1;
               end
               if (in_last) state_d = StFlush;
            end
         end
         StFlush: begin
            emit      = in_num_q;
            clear_num = 1'b1;
            if (neg_q && !in_num_q) error_d = 1'b1;
            state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (clear_num) begin
         acc_d    = '0;
         neg_d    = 1'b0;
         in_num_d = 1'b0;
`ifdef ASCII_NUM_HEX_EN
         hex_d        = 1'b0;
         first_zero_d = 1'b0;
`endif
      end

      if (emit) begin
         if (num_count_q == DEPTH_C) begin
            error_d = 1'b1;
         end else begin
            wr_en_d     = 1'b1;
            wr_addr_d   = num_count_q[ADDR_WIDTH-1:0];
            wr_data_d   = emit_val;
            num_count_d = num_count_q + CW'(1);
         end
         if (emit_ovf) error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         clr_cnt_q    <= '0;
         acc_q        <= '0;
         neg_q        <= 1'b0;
         in_num_q     <= 1'b0;
         num_count_q  <= '0;
         error_q      <= 1'b0;
         ram_clear_q  <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
`ifdef ASCII_NUM_HEX_EN
         hex_q        <= 1'b0;
         first_zero_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         acc_q        <= acc_d;
         neg_q        <= neg_d;
         in_num_q     <= in_num_d;
         num_count_q  <= num_count_d;
         error_q      <= error_d;
         ram_clear_q  <= ram_clear_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
`ifdef ASCII_NUM_HEX_EN
         hex_q        <= hex_d;
         first_zero_q <= first_zero_d;
`endif
      end
   end

   assign in_ready    = (state_q == StParse);
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign ram_clear   = ram_clear_q;
   assign ram_wr_en   = wr_en_q;
   assign ram_wr_addr = wr_addr_q;
   assign ram_wr_data = wr_data_q;
   assign num_count   = num_count_q;
   assign error       = error_q;

endmodule
